// File: rtl/cla_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial
// subtraction done by a borrow-lookahead subtractor, valid/ready on both sides.
module cla_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   sub_res;
  logic             bout;
  logic [WIDTH-1:0] step_rem;

  // Borrow into bit position i as a flat sum of products: no ripple chain.
  function automatic logic borrow_into(input logic [WIDTH:0] g, input logic [WIDTH:0] p,
                                       input logic bin, input int i);
    logic res, term;
    res = bin;
    for (int k = 0; k < i; k++) res &= p[k];
    for (int j = 0; j < i; j++) begin
      term = g[j];
      for (int k = j + 1; k < i; k++) term &= p[k];
      res |= term;
    end
    return res;
  endfunction

  // Returns {borrow_out, low WIDTH bits of a - b}.
  function automatic logic [WIDTH:0] bla_sub(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH:0]   g, p;
    logic [WIDTH-1:0] brw;
    logic             bo;
    g = ~a & b;
    p = ~(a ^ b);
    for (int i = 0; i < WIDTH; i++) brw[i] = borrow_into(g, p, 1'b0, i);
    bo = borrow_into(g, p, 1'b0, WIDTH + 1);
    return {bo, a[WIDTH-1:0] ^ b[WIDTH-1:0] ^ brw};
  endfunction

  // Restored/reduced remainder always fits WIDTH bits; the WIDTH+1-bit
  // quantity is the trial operand.
  assign trial_a  = {prem_q, shreg_q[WIDTH-1]};
  assign sub_res  = bla_sub(trial_a, {1'b0, dvsr_q});
  assign bout     = sub_res[WIDTH];
  assign step_rem = bout ? trial_a[WIDTH-1:0] : sub_res[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prem_d  = prem_q;
    shreg_d = shreg_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = dividend;
          dvsr_d  = divisor;
          prem_d  = '0;
          count_d = '0;
          if (divisor != '0) begin
            state_d = BUSY;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB.
        prem_d  = step_rem;
        shreg_d = {shreg_q[WIDTH-2:0], ~bout};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          quot_d  = {shreg_q[WIDTH-2:0], ~bout};
          rem_d   = step_rem;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      prem_q  <= '0;
      shreg_q <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prem_q  <= prem_d;
      shreg_q <= shreg_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == BUSY);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
